// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start detect, mid-bit sampling, optional parity,
// 1/2 stop bits, and a valid/ready holding register with parity/framing/overrun flags.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clkEn,
  input  logic                 serialData,
  output logic [DATA_BITS-1:0] outputData,
  output logic                 dataValid,
  input  logic                 dataReady,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 overrunError
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [1:0]           sync_q;
  logic                 rxS;
  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d, frm_q, frm_d;
  logic                 done, load, mid;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_q, fe_q, ovr_q;

  assign rxS = sync_q[1];
  assign mid = (tick_q == FULL_M1);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    frm_d   = frm_q;
    done    = 1'b0;
    if (clkEn) begin
      case (state_q)
        IDLE: if (!rxS) begin
          state_d = START;
          tick_d  = '0;
        end
        START: if (tick_q == HALF_M1) begin
          tick_d = '0;
          if (rxS) state_d = IDLE;  // glitch, not a real start bit
          else begin
            state_d = DATA;
            bit_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
            frm_d   = 1'b0;
          end
        end else tick_d = tick_q + 1'b1;
        DATA: if (mid) begin
          tick_d = '0;
          for (int i = 0; i < DATA_BITS; i++)
            if (bit_q == BW'(i)) shift_d[i] = rxS;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 1'b1;
        PARITY: if (mid) begin
          tick_d  = '0;
          par_d   = ((^shift_q) ^ rxS) != (PARITY_ODD != 0);
          state_d = STOP;
        end else tick_d = tick_q + 1'b1;
        STOP: if (mid) begin
          tick_d = '0;
          if (!rxS) frm_d = 1'b1;
          // Leave at the last stop sample so the next start edge is caught at once
          if (bit_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = IDLE;
          end else bit_d = bit_q + 1'b1;
        end else tick_d = tick_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  assign load = done && (!valid_q || dataReady);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], serialData};
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
      ovr_q   <= done && !load;
      if (load) begin
        data_q  <= shift_d;
        pe_q    <= par_d;
        fe_q    <= frm_d;
        valid_q <= 1'b1;
      end else if (valid_q && dataReady) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign outputData   = data_q;
  assign dataValid    = valid_q;
  assign parityError  = pe_q;
  assign frameError   = fe_q;
  assign overrunError = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two instances (8N1/x16 with clkEn every clk, and 5E2/x8 with
// clkEn every 3rd clk) driven by a frame-level model with an expected-frame queue each.
module tb_uart_rx_param;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    bit         drop;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cen [2];
  logic       ser [2];
  logic       rdy [2];
  logic       vld [2];
  logic       pe_o [2];
  logic       fe_o [2];
  logic       ov [2];
  logic [7:0] datA;
  logic [4:0] datB;
  logic [8:0] dat [2];

  int  total = 0, bad = 0, cyc = 0;
  int  cmode [2] = '{0, 1};
  int  tgt [2] = '{0, 0};
  logic rst_seen = 1'b1;
  logic rdy_seen [2] = '{1'b0, 1'b0};
  logic p_v [2] = '{1'b0, 1'b0};
  logic p_pe [2] = '{1'b0, 1'b0};
  logic p_fe [2] = '{1'b0, 1'b0};
  logic p_ov [2] = '{1'b0, 1'b0};
  logic [8:0] p_d [2] = '{9'd0, 9'd0};
  int  last_d [2], last_lat [2], last_pe [2], last_fe [2], last_b2b [2];
  int  ovcnt [2] = '{0, 0};
  frame_t q0[$], q1[$];

  uart_rx_param dutA (
    .clk(clk), .rstN(rstN), .clkEn(cen[0]), .serialData(ser[0]), .outputData(datA),
    .dataValid(vld[0]), .dataReady(rdy[0]), .parityError(pe_o[0]), .frameError(fe_o[0]),
    .overrunError(ov[0]));

  uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dutB (
    .clk(clk), .rstN(rstN), .clkEn(cen[1]), .serialData(ser[1]), .outputData(datB),
    .dataValid(vld[1]), .dataReady(rdy[1]), .parityError(pe_o[1]), .frameError(fe_o[1]),
    .overrunError(ov[1]));

  assign dat[0] = {1'b0, datA};
  assign dat[1] = {4'b0, datB};

  always #5 clk = ~clk;

  function automatic int f_db(input int k); return (k == 0) ? 8 : 5; endfunction
  function automatic int f_os(input int k); return (k == 0) ? 16 : 8; endfunction
  function automatic int f_pe(input int k); return (k == 0) ? 0 : 1; endfunction
  function automatic int f_po(input int k); return 0; endfunction
  function automatic int f_sb(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int f_per(input int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int f_nb(input int k); return 1 + f_db(k) + f_pe(k) + f_sb(k); endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic frame_t qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_seen    <= rstN;
    rdy_seen[0] <= rdy[0];
    rdy_seen[1] <= rdy[1];
  end

  // clkEn sources: instance A every clk, instance B every 3rd clk
  initial begin
    int ph = 0;
    cen[0] = 1'b1;
    cen[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 3;
      cen[1] = (ph == 0);
    end
  end

  // Consumer: 0 hold low, 1 random, 2 single pulse before edge tgt, 3 hold high
  initial begin
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        case (cmode[k])
          0:       rdy[k] = 1'b0;
          1:       rdy[k] = 1'($urandom_range(0, 1));
          2:       rdy[k] = (cyc == tgt[k]);
          default: rdy[k] = 1'b1;
        endcase
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic chk(input int k);
    frame_t e;
    int lat, expl;
    bit ok;
    if (!rst_seen) begin
      total++;
      if (vld[k] || dat[k] != 9'd0 || pe_o[k] || fe_o[k] || ov[k]) begin
        bad++;
        $display("FAIL reset%0d: got v=%b d=%h pe=%b fe=%b ov=%b want all 0",
                 k, vld[k], dat[k], pe_o[k], fe_o[k], ov[k]);
      end
    end else begin
      if (vld[k] && (!p_v[k] || rdy_seen[k])) begin
        total++;
        if (qsize(k) == 0) begin
          bad++;
          $display("FAIL load%0d: got unexpected frame d=%h want no frame", k, dat[k]);
        end else begin
          e = qpop(k);
          lat  = cyc - e.start;
          expl = (f_nb(k) * f_os(k) - f_os(k) / 2) * f_per(k) + 3;
          if (e.drop || dat[k] != e.data || pe_o[k] != e.pe || fe_o[k] != e.fe) begin
            bad++;
            $display("FAIL load%0d: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b drop=%0d",
                     k, dat[k], pe_o[k], fe_o[k], e.data, e.pe, e.fe, e.drop);
          end
          check($sformatf("latency%0d", k), int'(lat >= expl - 1 && lat <= expl + f_per(k) + 1), 1);
          last_d[k] = dat[k]; last_pe[k] = pe_o[k]; last_fe[k] = fe_o[k];
          last_lat[k] = lat; last_b2b[k] = p_v[k];
        end
      end else if (p_v[k] && !rdy_seen[k]) begin
        total++;
        if (!vld[k] || dat[k] != p_d[k] || pe_o[k] != p_pe[k] || fe_o[k] != p_fe[k]) begin
          bad++;
          $display("FAIL hold%0d: got v=%b d=%h want v=1 d=%h", k, vld[k], dat[k], p_d[k]);
        end
      end
      if (ov[k]) begin
        total++;
        ok = !p_ov[k] && p_v[k] && !rdy_seen[k] && qsize(k) != 0;
        if (qsize(k) != 0) begin
          e = qpop(k);
          ok = ok && e.drop;
        end
        ovcnt[k]++;
        if (!ok) begin
          bad++;
          $display("FAIL overrun%0d: got pulse (prev ov=%b v=%b rdy=%b) want no pulse",
                   k, p_ov[k], p_v[k], rdy_seen[k]);
        end
      end
    end
    p_v[k] = vld[k]; p_d[k] = dat[k]; p_pe[k] = pe_o[k]; p_fe[k] = fe_o[k]; p_ov[k] = ov[k];
  endtask

  always @(negedge clk) begin
    chk(0);
    chk(1);
  end

  task automatic tick_wait(input int k, input int n);
    int c = 0;
    if (n == 0) return;
    while (c < n) begin
      @(posedge clk);
      if (cen[k]) c++;
    end
    #1;
  endtask

  task automatic send(input int k, input logic [8:0] d, input logic pbit,
                      input logic s0, input logic s1, input bit drop, input int gap);
    frame_t e;
    logic [8:0] m;
    m      = (9'd1 << f_db(k)) - 9'd1;
    e.data = d & m;
    e.pe   = (f_pe(k) != 0) && (((^e.data) ^ pbit) != (f_po(k) != 0));
    e.fe   = !s0 || (f_sb(k) == 2 && !s1);
    e.drop = drop;
    tick_wait(k, 1);
    e.start = cyc;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    ser[k] = 1'b0;
    tick_wait(k, f_os(k));
    for (int i = 0; i < f_db(k); i++) begin
      ser[k] = e.data[i];
      tick_wait(k, f_os(k));
    end
    if (f_pe(k) != 0) begin
      ser[k] = pbit;
      tick_wait(k, f_os(k));
    end
    ser[k] = s0;
    tick_wait(k, f_os(k));
    if (f_sb(k) == 2) begin
      ser[k] = s1;
      tick_wait(k, f_os(k));
    end
    ser[k] = 1'b1;
    tick_wait(k, f_os(k) * gap);
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (qsize(k) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (qsize(k) != 0) begin
      bad++;
      $display("FAIL timeout%0d: got %0d frames pending want 0", k, qsize(k));
      if (k == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic rand_frames(input int k, input int n);
    logic s0, s1;
    for (int i = 0; i < n; i++) begin
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      send(k, 9'($urandom), 1'($urandom), s0, s1, 1'b0,
           (!s0 || !s1) ? 2 : int'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0;
    ser[0] = 1'b1;
    ser[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1 rstN = 1'b1;

    // 8N1 0xA5, held then accepted
    send(0, 9'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    wait_done(0, 400);
    check("a5_data", last_d[0], 'hA5);
    check("a5_lat", last_lat[0], 155);
    check("a5_flags", {last_pe[0], last_fe[0]}, 0);
    check("a5_held", vld[0], 1);
    cmode[0] = 3;
    repeat (3) @(posedge clk);
    #1 check("a5_accept", vld[0], 0);
    cmode[0] = 1;

    // glitch shorter than half a bit, then a real frame
    tick_wait(0, 1);
    ser[0] = 1'b0;
    tick_wait(0, 4);
    ser[0] = 1'b1;
    tick_wait(0, 32);
    check("glitch_noval", vld[0], 0);
    send(0, 9'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    wait_done(0, 400);
    check("3c_data", last_d[0], 'h3C);

    // overrun, then a same-cycle accept/load
    cmode[0] = 3;
    repeat (3) @(posedge clk);
    cmode[0] = 0;
    send(0, 9'h11, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    send(0, 9'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1);
    wait_done(0, 400);
    check("ovr_held", dat[0], 'h11);
    check("ovr_count", ovcnt[0], 1);
    tick_wait(0, 1);
    tgt[0] = cyc + 155;
    cmode[0] = 2;
    send(0, 9'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    wait_done(0, 400);
    check("b2b_data", last_d[0], 'h33);
    check("b2b_cont", last_b2b[0], 1);
    check("b2b_noovr", ovcnt[0], 1);
    cmode[0] = 1;

    // 5-bit even parity, two stop bits
    send(1, 9'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    wait_done(1, 600);
    check("par_ok_d", last_d[1], 'h07);
    check("par_ok_pe", last_pe[1], 0);
    send(1, 9'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    wait_done(1, 600);
    check("par_bad_d", last_d[1], 'h07);
    check("par_bad_pe", last_pe[1], 1);
    send(1, 9'h15, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    wait_done(1, 600);
    check("frm_d", last_d[1], 'h15);
    check("frm_fe", last_fe[1], 1);

    // reset in the middle of a data bit while a frame is held
    cmode[1] = 3;
    repeat (6) @(posedge clk);
    cmode[1] = 0;
    send(1, 9'h1B, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    wait_done(1, 600);
    check("rst_pre_d", dat[1], 'h1B);
    tick_wait(1, 1);
    ser[1] = 1'b0;
    tick_wait(1, 28);
    rstN = 1'b0;
    ser[1] = 1'b1;
    @(posedge clk);
    #1 rstN = 1'b1;
    check("rst_vld", vld[1], 0);
    check("rst_dat", dat[1], 0);
    cmode[1] = 1;
    tick_wait(1, 16);
    send(1, 9'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    wait_done(1, 600);
    check("post_rst_d", last_d[1], 'h0A);
    check("post_rst_flags", {last_pe[1], last_fe[1]}, 0);

    // random frames on both lines at once
    fork
      rand_frames(0, 12);
      rand_frames(1, 12);
    join
    wait_done(0, 600);
    wait_done(1, 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
